// File: rtl/cr_tlvp2_split_pkg.sv
// Shared definitions for the TLV ingress splitter: header field layout,
// the per-port output word and the parser state encoding.
package cr_tlvp2_split_pkg;

    // Header word layout (low 32 bits of the data word)
    localparam int TLV_TYPE_LSB = 0;
    localparam int TLV_TYPE_W   = 8;
    localparam int TLV_LEN_LSB  = 8;
    localparam int TLV_LEN_W    = 24;

    // Width of the data field carried through the output registers.
    // The top's N_DATA_BITS is expected to match this value.
    localparam int TLV_DATA_W   = 64;

    // One word as presented on either output port
    typedef struct packed {
        logic [TLV_DATA_W-1:0] data;
        logic                  sot;
        logic                  eot;
        logic [TLV_TYPE_W-1:0] tlv_type;
    } tlvp2_split_word_t;

    // Parser state: waiting for a header, or inside a TLV body
    typedef enum logic {
        HDR  = 1'b0,
        BODY = 1'b1
    } tlvp2_split_state_e;

    // Extract the length field (word count including the header)
    function automatic logic [TLV_LEN_W-1:0] tlv_len(input logic [31:0] hdr);
        return hdr[TLV_LEN_LSB +: TLV_LEN_W];
    endfunction

    // Extract the type field
    function automatic logic [TLV_TYPE_W-1:0] tlv_type(input logic [31:0] hdr);
        return hdr[TLV_TYPE_LSB +: TLV_TYPE_W];
    endfunction

endpackage

// File: rtl/cr_tlvp2_split_oreg.sv
// Single-entry valid/ready holding register for one output port.
// 'free' is high when a new word may be loaded this cycle: the register is
// empty, or its current word is being taken downstream in the same cycle.
module cr_tlvp2_split_oreg
    import cr_tlvp2_split_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  tlvp2_split_word_t d,
    input  logic              ready,
    output logic              valid,
    output tlvp2_split_word_t q,
    output logic              free
);

    assign free = !valid || ready;

    // Load a new word (possibly replacing one being drained), else empty on drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cr_tlvp2_split.sv
// TLV ingress splitter: parses TLV headers from an AXI4-stream word stream
// and steers each TLV to the passthrough or user port by a type mask.
// Optional feature macro: CR_TLVP2_SPLIT_STATS_EN enables the per-port
// saturating TLV counters; without it the counter ports read 0.
module cr_tlvp2_split
    import cr_tlvp2_split_pkg::*;
#(
    parameter int           N_DATA_BITS   = 64,
    parameter logic [255:0] USR_TYPE_MASK = 256'h0,
    parameter int           MAX_LEN       = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ib_tvalid,
    output logic                   ib_tready,
    input  logic [N_DATA_BITS-1:0] ib_tdata,
    input  logic                   ib_tlast,
    output logic                   pt_ib_valid,
    input  logic                   pt_ib_ready,
    output logic [N_DATA_BITS-1:0] pt_ib_data,
    output logic                   pt_ib_sot,
    output logic                   pt_ib_eot,
    output logic [7:0]             pt_ib_type,
    output logic                   usr_ib_valid,
    input  logic                   usr_ib_ready,
    output logic [N_DATA_BITS-1:0] usr_ib_data,
    output logic                   usr_ib_sot,
    output logic                   usr_ib_eot,
    output logic [7:0]             usr_ib_type,
    output logic                   split_err,
    output logic [31:0]            pt_tlv_cnt,
    output logic [31:0]            usr_tlv_cnt
);

    localparam logic [TLV_LEN_W:0] MAX_LEN_V = (TLV_LEN_W+1)'(MAX_LEN);

    tlvp2_split_state_e    state;
    logic [TLV_LEN_W-1:0]  remain;
    logic                  route_usr;
    logic [TLV_TYPE_W-1:0] cur_type;
    logic                  live;

    logic [TLV_TYPE_W-1:0] hdr_type;
    logic [TLV_LEN_W-1:0]  hdr_len;
    logic                  hdr_usr;
    logic                  hdr_bad;

    tlvp2_split_word_t     in_word;
    logic                  tgt_usr;
    logic                  err_now;
    logic                  accept;
    logic                  pt_free, usr_free;
    tlvp2_split_word_t     pt_q, usr_q;

    // Header decode is valid only in HDR but is cheap to keep always live
    assign hdr_type = tlv_type(ib_tdata[31:0]);
    assign hdr_len  = tlv_len(ib_tdata[31:0]);
    assign hdr_usr  = USR_TYPE_MASK[hdr_type];
    assign hdr_bad  = (hdr_len == '0) || ({1'b0, hdr_len} > MAX_LEN_V);

    // Build the outgoing word and pick the target port for the current input
    always_comb begin
        in_word      = '0;
        in_word.data = TLV_DATA_W'(ib_tdata);
        tgt_usr      = route_usr;
        err_now      = 1'b0;
        if (state == HDR) begin
            // Bad, single-word or tlast-terminated headers close immediately
            tgt_usr          = hdr_usr;
            in_word.sot      = 1'b1;
            in_word.eot      = hdr_bad || (hdr_len == TLV_LEN_W'(1)) || ib_tlast;
            in_word.tlv_type = hdr_type;
            err_now          = hdr_bad;
        end else begin
            // tlast before the count expires truncates the TLV
            in_word.eot      = (remain == TLV_LEN_W'(1)) || ib_tlast;
            in_word.tlv_type = cur_type;
            err_now          = ib_tlast && (remain != TLV_LEN_W'(1));
        end
    end

    // Only the target port's register gates the input; the other never stalls it
    assign ib_tready = live && (tgt_usr ? usr_free : pt_free);
    assign accept    = ib_tvalid && ib_tready;

    // Hold off input acceptance until the first clock after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) live <= 1'b0;
        else     live <= 1'b1;
    end

    // Parser FSM: latch route/type/length at the header, count down the body
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HDR;
            remain    <= '0;
            route_usr <= 1'b0;
            cur_type  <= '0;
            split_err <= 1'b0;
        end else begin
            split_err <= accept && err_now;
            if (accept) begin
                case (state)
                    HDR: begin
                        if (!in_word.eot) begin
                            state     <= BODY;
                            remain    <= hdr_len - TLV_LEN_W'(1);
                            route_usr <= hdr_usr;
                            cur_type  <= hdr_type;
                        end
                    end
                    BODY: begin
                        if (in_word.eot) state <= HDR;
                        else             remain <= remain - TLV_LEN_W'(1);
                    end
                    default: state <= HDR;
                endcase
            end
        end
    end

    cr_tlvp2_split_oreg u_pt_oreg (
        .clk   (clk),
        .rst   (rst),
        .load  (accept && !tgt_usr),
        .d     (in_word),
        .ready (pt_ib_ready),
        .valid (pt_ib_valid),
        .q     (pt_q),
        .free  (pt_free)
    );

    cr_tlvp2_split_oreg u_usr_oreg (
        .clk   (clk),
        .rst   (rst),
        .load  (accept && tgt_usr),
        .d     (in_word),
        .ready (usr_ib_ready),
        .valid (usr_ib_valid),
        .q     (usr_q),
        .free  (usr_free)
    );

    assign pt_ib_data  = N_DATA_BITS'(pt_q.data);
    assign pt_ib_sot   = pt_q.sot;
    assign pt_ib_eot   = pt_q.eot;
    assign pt_ib_type  = pt_q.tlv_type;
    assign usr_ib_data = N_DATA_BITS'(usr_q.data);
    assign usr_ib_sot  = usr_q.sot;
    assign usr_ib_eot  = usr_q.eot;
    assign usr_ib_type = usr_q.tlv_type;

`ifdef CR_TLVP2_SPLIT_STATS_EN
    logic [31:0] pt_cnt_q, usr_cnt_q;

    // Count EOT words taken downstream on each port, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pt_cnt_q  <= '0;
            usr_cnt_q <= '0;
        end else begin
            if (pt_ib_valid && pt_ib_ready && pt_ib_eot && (pt_cnt_q != '1))
                pt_cnt_q <= pt_cnt_q + 32'd1;
            if (usr_ib_valid && usr_ib_ready && usr_ib_eot && (usr_cnt_q != '1))
                usr_cnt_q <= usr_cnt_q + 32'd1;
        end
    end

    assign pt_tlv_cnt  = pt_cnt_q;
    assign usr_tlv_cnt = usr_cnt_q;
`else
    assign pt_tlv_cnt  = '0;
    assign usr_tlv_cnt = '0;
`endif

endmodule

// File: tb/tb_cr_tlvp2_split.sv
// Self-checking bench for cr_tlvp2_split: directed scenarios plus random
// TLV traffic, checked cycle by cycle against a TLV-level reference model.
module tb_cr_tlvp2_split;

    localparam int DW   = 64;
    localparam int MAXL = 4096;
    // Types 0x10 and 0xE8..0xEF go to the user port
    localparam logic [255:0] MASK =
        256'h0000_FF00_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0001_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          ib_tvalid, ib_tready, ib_tlast;
    logic [DW-1:0] ib_tdata;
    logic          pt_ib_valid, pt_ib_ready, pt_ib_sot, pt_ib_eot;
    logic [DW-1:0] pt_ib_data;
    logic [7:0]    pt_ib_type;
    logic          usr_ib_valid, usr_ib_ready, usr_ib_sot, usr_ib_eot;
    logic [DW-1:0] usr_ib_data;
    logic [7:0]    usr_ib_type;
    logic          split_err;
    logic [31:0]   pt_tlv_cnt, usr_tlv_cnt;

    always #5 clk = ~clk;

    cr_tlvp2_split #(.N_DATA_BITS(DW), .USR_TYPE_MASK(MASK), .MAX_LEN(MAXL)) dut (
        .clk(clk), .rst(rst),
        .ib_tvalid(ib_tvalid), .ib_tready(ib_tready), .ib_tdata(ib_tdata), .ib_tlast(ib_tlast),
        .pt_ib_valid(pt_ib_valid), .pt_ib_ready(pt_ib_ready), .pt_ib_data(pt_ib_data),
        .pt_ib_sot(pt_ib_sot), .pt_ib_eot(pt_ib_eot), .pt_ib_type(pt_ib_type),
        .usr_ib_valid(usr_ib_valid), .usr_ib_ready(usr_ib_ready), .usr_ib_data(usr_ib_data),
        .usr_ib_sot(usr_ib_sot), .usr_ib_eot(usr_ib_eot), .usr_ib_type(usr_ib_type),
        .split_err(split_err), .pt_tlv_cnt(pt_tlv_cnt), .usr_tlv_cnt(usr_tlv_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic          sot;
        logic          eot;
        logic [7:0]    t;
    } ew_t;

    ew_t  ptq[$];
    ew_t  usrq[$];
    int   m_left;        // words still owed by the open TLV (0 = expecting header)
    logic m_usr;
    logic [7:0] m_type;
    logic err_pend;
    int   exp_pt_cnt, exp_usr_cnt, usr_out;
    logic tb_live;
    int   rmode;         // 0: both ready, 1: random, 2: usr stalled

    function automatic void push(input logic u, input logic [DW-1:0] d,
                                 input logic s, input logic e, input logic [7:0] t);
        ew_t w;
        w.d = d; w.sot = s; w.eot = e; w.t = t;
        if (u) usrq.push_back(w);
        else   ptq.push_back(w);
    endfunction

    function automatic void model_step(input logic [DW-1:0] d, input logic last);
        int len;
        logic [7:0] t;
        logic u, bad;
        if (m_left == 0) begin
            t   = d[7:0];
            len = int'(d[31:8]);
            u   = MASK[t];
            bad = (len == 0) || (len > MAXL);
            if (bad) err_pend = 1'b1;
            if (bad || len == 1 || last) push(u, d, 1'b1, 1'b1, t);
            else begin
                push(u, d, 1'b1, 1'b0, t);
                m_left = len - 1; m_usr = u; m_type = t;
            end
        end else begin
            if (last && m_left > 1) err_pend = 1'b1;
            push(m_usr, d, 1'b0, (m_left == 1) || last, m_type);
            m_left = last ? 0 : m_left - 1;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) tb_live <= 1'b0;
        else     tb_live <= 1'b1;
    end

    // Cycle monitor: outputs must match the model queues exactly
    logic tgt, exp_rdy;
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ctl", {pt_ib_valid, usr_ib_valid, ib_tready, split_err}, 4'b0);
            chk("rst_out", {pt_ib_data, pt_ib_sot, pt_ib_eot, pt_ib_type,
                            usr_ib_sot, usr_ib_eot, usr_ib_type}, '0);
            chk("rst_usr_data", usr_ib_data, '0);
            chk("rst_cnt", {pt_tlv_cnt, usr_tlv_cnt}, '0);
            ptq.delete(); usrq.delete();
            m_left = 0; err_pend = 1'b0; exp_pt_cnt = 0; exp_usr_cnt = 0;
        end else begin
            tgt = (m_left == 0) ? MASK[ib_tdata[7:0]] : m_usr;
            exp_rdy = tb_live && (tgt ? (usrq.size() == 0 || usr_ib_ready)
                                      : (ptq.size() == 0 || pt_ib_ready));
            chk("tready", ib_tready, exp_rdy);
            chk("pt_valid", pt_ib_valid, ptq.size() != 0);
            chk("usr_valid", usr_ib_valid, usrq.size() != 0);
            if (ptq.size() != 0)
                chk("pt_word", {pt_ib_data, pt_ib_sot, pt_ib_eot, pt_ib_type},
                    {ptq[0].d, ptq[0].sot, ptq[0].eot, ptq[0].t});
            if (usrq.size() != 0)
                chk("usr_word", {usr_ib_data, usr_ib_sot, usr_ib_eot, usr_ib_type},
                    {usrq[0].d, usrq[0].sot, usrq[0].eot, usrq[0].t});
            chk("split_err", split_err, err_pend);
            err_pend = 1'b0;
            if (pt_ib_valid && pt_ib_ready && ptq.size() != 0) begin
                if (ptq[0].eot) exp_pt_cnt++;
                void'(ptq.pop_front());
            end
            if (usr_ib_valid && usr_ib_ready && usrq.size() != 0) begin
                if (usrq[0].eot) exp_usr_cnt++;
                usr_out++;
                void'(usrq.pop_front());
            end
            if (ib_tvalid && ib_tready) model_step(ib_tdata, ib_tlast);
        end
    end

    // Downstream ready generator
    initial begin
        pt_ib_ready = 1'b1; usr_ib_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                1:       begin pt_ib_ready = ($urandom_range(0, 3) != 0);
                               usr_ib_ready = ($urandom_range(0, 3) != 0); end
                2:       begin pt_ib_ready = 1'b1; usr_ib_ready = 1'b0; end
                default: begin pt_ib_ready = 1'b1; usr_ib_ready = 1'b1; end
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [DW-1:0] hdr(input int len, input logic [7:0] t);
        logic [23:0] l;
        l = 24'(len);
        return {$urandom(), l, t};
    endfunction

    task automatic send(input logic [DW-1:0] d, input logic last);
        bit ok;
        ok = 0;
        ib_tvalid = 1'b1; ib_tdata = d; ib_tlast = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ib_tready) begin ok = 1; break; end
        end
        if (!ok) chk("tready_timeout", 0, 1);
        @(posedge clk); #1;
        ib_tvalid = 1'b0; ib_tlast = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        rmode = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ptq.size() == 0 && usrq.size() == 0) begin ok = 1; break; end
        end
        if (!ok) chk("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic chk_cnt(input string tag);
`ifdef CR_TLVP2_SPLIT_STATS_EN
        chk({tag, "_pt_cnt"}, pt_tlv_cnt, exp_pt_cnt);
        chk({tag, "_usr_cnt"}, usr_tlv_cnt, exp_usr_cnt);
`else
        chk({tag, "_pt_cnt"}, pt_tlv_cnt, 0);
        chk({tag, "_usr_cnt"}, usr_tlv_cnt, 0);
`endif
    endtask

    task automatic rand_tlv();
        int len, nw, lastpos, k;
        logic [7:0] t;
        logic lastfinal;
        case ($urandom_range(0, 3))
            0:       t = 8'h05;
            1:       t = 8'h10;
            2:       t = 8'hE8;
            default: t = 8'($urandom_range(0, 255));
        endcase
        k = $urandom_range(0, 19);
        if (k == 0)      len = 0;
        else if (k == 1) len = MAXL + 1 + $urandom_range(0, 3);
        else             len = $urandom_range(1, 6);
        lastfinal = $urandom_range(0, 1);
        if (len == 0 || len > MAXL) begin nw = 1; lastpos = -1; end
        else if (len > 2 && $urandom_range(0, 7) == 0) begin
            lastpos = $urandom_range(1, len - 2); nw = lastpos + 1;
        end else begin
            nw = len; lastpos = lastfinal ? len - 1 : -1;
        end
        send(hdr(len, t), lastpos == 0);
        for (int i = 1; i < nw; i++) begin
            send({$urandom(), $urandom()}, i == lastpos);
            if ($urandom_range(0, 5) == 0) begin @(posedge clk); #1; end
        end
    endtask

    // ---------------- scenarios ----------------
    int usr_base;
    initial begin
        rst = 1'b1; ib_tvalid = 1'b0; ib_tdata = '0; ib_tlast = 1'b0; rmode = 0;
        m_left = 0; err_pend = 1'b0; exp_pt_cnt = 0; exp_usr_cnt = 0; usr_out = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk_cnt("reset");

        // Type 0x05 len 3 to passthrough
        send(hdr(3, 8'h05), 1'b0);
        send(64'h1111_2222_3333_4444, 1'b0);
        send(64'h5555_6666_7777_8888, 1'b0);
        drain();
        chk("t1_usr_out", usr_out, 0);
        chk_cnt("t1");

        // Interleaved user then passthrough, back to back
        send(hdr(2, 8'h10), 1'b0);
        send(64'hDEAD_BEEF_0000_0001, 1'b0);
        send(hdr(1, 8'h05), 1'b0);
        drain();
        chk("t2_usr_out", usr_out, 2);
        chk_cnt("t2");

        // Backpressure on the user port mid-TLV
        usr_base = usr_out;
        rmode = 2;
        fork
            begin
                send(hdr(4, 8'h10), 1'b0);
                send(64'hA0, 1'b0);
                send(64'hA1, 1'b0);
                send(64'hA2, 1'b0);
            end
            begin
                repeat (6) @(negedge clk);
                chk("bp_tready", ib_tready, 0);
                chk("bp_valid", usr_ib_valid, 1);
                rmode = 0;
            end
        join
        drain();
        chk("bp_words", usr_out - usr_base, 4);

        // Truncation: len 6, tlast on word 3
        send(hdr(6, 8'h05), 1'b0);
        send(64'hB1, 1'b0);
        send(64'hB2, 1'b0);
        send(64'hB3, 1'b1);
        send(hdr(1, 8'h10), 1'b0);
        drain();

        // Bad headers, then a legal TLV to show the parser stayed in HDR
        send(hdr(0, 8'h05), 1'b0);
        send(hdr(MAXL + 1, 8'h10), 1'b0);
        send(hdr(2, 8'h05), 1'b0);
        send(64'hC1, 1'b0);
        drain();
        chk_cnt("bad");

        // Reset in the middle of a body
        send(hdr(8, 8'h10), 1'b0);
        send(64'hD1, 1'b0);
        send(64'hD2, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(hdr(1, 8'h05), 1'b0);
        drain();
        chk_cnt("post_rst");

        // Random traffic with random downstream readiness
        rmode = 1;
        for (int n = 0; n < 300; n++) rand_tlv();
        drain();
        chk_cnt("rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
